// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
// Holds the FSM state encoding and the shared-timer width calculation.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    RESET_PLL   = 2'd0,
    WAIT_LOCK   = 2'd1,
    STABLE_WAIT = 2'd2,
    RUN         = 2'd3
  } pll_state_e;

  // One timer serves every state, so it must hold the largest of the three terminal counts.
  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with asynchronous active-high reset to 0.
// q_next_o exposes the first stage: the value q_o will take on the next edge.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic q_next_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o      = sync_q;
  assign q_next_o = meta_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Pulses PLL reset, waits for lock with timeout/retry, qualifies lock stability,
// then releases the downstream system reset. Single refclk domain.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int CNT_W         = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             locked_in,
  input  logic             relock_req,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             ready,
  output logic [CNT_W-1:0] retry_cnt,
  output logic [CNT_W-1:0] loss_cnt,
  output logic [1:0]       state_o
);

  localparam int TW = timer_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [TW-1:0]    RST_LAST    = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0]    TO_LAST     = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0]    STABLE_LAST = TW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0]    TIMER_ONE   = TW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  pll_state_e       state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0] retry_q, retry_d;
  logic [CNT_W-1:0] loss_q, loss_d;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_rst_q, sys_rst_d;
  logic             ready_q, ready_d;
  logic             lock_s;
  logic             lock_nxt;

  sync_2ff u_lock_sync (
    .clk_i    (refclk),
    .rst_i    (rst),
    .d_i      (locked_in),
    .q_o      (lock_s),
    .q_next_o (lock_nxt)
  );

  // Decisions use the value lock_s takes on this edge, so state reacts on the
  // same edge that lock_s changes.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    case (state_q)
      RESET_PLL: begin
        if (timer_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_nxt) begin
          state_d = STABLE_WAIT;
        end else if (timer_q == TO_LAST) begin
          state_d = RESET_PLL;
          retry_d = sat_inc(retry_q);
        end
      end
      STABLE_WAIT: begin
        if (!lock_nxt) state_d = WAIT_LOCK;
        else if (timer_q == STABLE_LAST) state_d = RUN;
      end
      RUN: begin
        if (lock_s && !lock_nxt) begin
          state_d = RESET_PLL;
          loss_d  = sat_inc(loss_q);
        end else if (relock_req) begin
          state_d = RESET_PLL;
        end
      end
      default: state_d = RESET_PLL;
    endcase

    timer_d   = ((state_d != state_q) || (state_q == RUN)) ? '0 : timer_q + TIMER_ONE;
    pll_rst_d = (state_d == RESET_PLL);
    sys_rst_d = (state_d != RUN);
    ready_d   = (state_d == RUN);
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= RESET_PLL;
      timer_q   <= '0;
      retry_q   <= '0;
      loss_q    <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst   = sys_rst_q;
  assign ready     = ready_q;
  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, CNT_W=2).
// Expected snapshots {state, pll_rst, sys_rst, ready, retry, loss} are queued per cycle offset.
module tb_pll_reset_sequencer;

  logic       refclk;
  logic       rst;
  logic       locked_in;
  logic       relock_req;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic [1:0] retry_cnt;
  logic [1:0] loss_cnt;
  logic [1:0] state_o;
  logic [8:0] obs;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      nm;
    int         at;
    logic [8:0] v;
  } exp_t;

  exp_t sb[$];

  pll_reset_sequencer #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (20),
    .STABLE_CYCLES(8),
    .CNT_W        (2)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .locked_in (locked_in),
    .relock_req(relock_req),
    .pll_rst   (pll_rst),
    .sys_rst   (sys_rst),
    .ready     (ready),
    .retry_cnt (retry_cnt),
    .loss_cnt  (loss_cnt),
    .state_o   (state_o)
  );

  assign obs = {state_o, pll_rst, sys_rst, ready, retry_cnt, loss_cnt};

  initial refclk = 1'b0;
  always #10 refclk = ~refclk;

  function automatic logic [8:0] pk(input logic [1:0] s, input logic p, input logic sy,
                                    input logic r, input logic [1:0] rc, input logic [1:0] lc);
    return {s, p, sy, r, rc, lc};
  endfunction

  function automatic void push(input string nm, input int at, input logic [8:0] v);
    exp_t e;
    e.nm = nm;
    e.at = at;
    e.v  = v;
    sb.push_back(e);
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge refclk);
    checks++;
    if (obs !== pk(2'd0, 1, 1, 0, 2'd0, 2'd0)) begin
      errors++;
      $display("FAIL reset_hold got %b expected %b", obs, pk(2'd0, 1, 1, 0, 2'd0, 2'd0));
    end
    @(negedge refclk);
    checks++;
    if (obs !== pk(2'd0, 1, 1, 0, 2'd0, 2'd0)) begin
      errors++;
      $display("FAIL reset_hold2 got %b expected %b", obs, pk(2'd0, 1, 1, 0, 2'd0, 2'd0));
    end
    rst = 1'b0;
  endtask

  task automatic test_lock_up();
    exp_t e;
    int last;
    push("lk_pll_hi1", 1,  pk(2'd0, 1, 1, 0, 2'd0, 2'd0));
    push("lk_pll_hi3", 3,  pk(2'd0, 1, 1, 0, 2'd0, 2'd0));
    push("lk_wait",    4,  pk(2'd1, 0, 1, 0, 2'd0, 2'd0));
    push("lk_stable",  5,  pk(2'd2, 0, 1, 0, 2'd0, 2'd0));
    push("lk_stable7", 12, pk(2'd2, 0, 1, 0, 2'd0, 2'd0));
    push("lk_run",     13, pk(2'd3, 0, 0, 1, 2'd0, 2'd0));
    last = sb[$].at;
    for (int c = 1; c <= last; c++) begin
      @(negedge refclk);
      while (sb.size() > 0 && sb[0].at == c) begin
        e = sb.pop_front();
        checks++;
        if (obs !== e.v) begin
          errors++;
          $display("FAIL %s cycle %0d got %b expected %b", e.nm, c, obs, e.v);
        end
      end
      if (c == 3) locked_in = 1'b1;
    end
  endtask

  task automatic test_run_loss();
    exp_t e;
    int last;
    locked_in = 1'b0;
    push("loss_still_run", 1,  pk(2'd3, 0, 0, 1, 2'd0, 2'd0));
    push("loss_reset",     2,  pk(2'd0, 1, 1, 0, 2'd0, 2'd1));
    push("loss_pll_hi",    5,  pk(2'd0, 1, 1, 0, 2'd0, 2'd1));
    push("loss_wait",      6,  pk(2'd1, 0, 1, 0, 2'd0, 2'd1));
    push("loss_stable",    7,  pk(2'd2, 0, 1, 0, 2'd0, 2'd1));
    push("loss_stable_end",14, pk(2'd2, 0, 1, 0, 2'd0, 2'd1));
    push("loss_rerun",     15, pk(2'd3, 0, 0, 1, 2'd0, 2'd1));
    last = sb[$].at;
    for (int c = 1; c <= last; c++) begin
      @(negedge refclk);
      while (sb.size() > 0 && sb[0].at == c) begin
        e = sb.pop_front();
        checks++;
        if (obs !== e.v) begin
          errors++;
          $display("FAIL %s cycle %0d got %b expected %b", e.nm, c, obs, e.v);
        end
      end
      if (c == 3) locked_in = 1'b1;
    end
  endtask

  task automatic test_relock();
    exp_t e;
    int last;
    relock_req = 1'b1;
    push("rl_reset",      1,  pk(2'd0, 1, 1, 0, 2'd0, 2'd1));
    push("rl_wait",       5,  pk(2'd1, 0, 1, 0, 2'd0, 2'd1));
    push("rl_stable",     6,  pk(2'd2, 0, 1, 0, 2'd0, 2'd1));
    push("rl_ignored",    9,  pk(2'd2, 0, 1, 0, 2'd0, 2'd1));
    push("rl_run",        14, pk(2'd3, 0, 0, 1, 2'd0, 2'd1));
    push("rl_both_pre",   15, pk(2'd3, 0, 0, 1, 2'd0, 2'd1));
    push("rl_both_reset", 16, pk(2'd0, 1, 1, 0, 2'd0, 2'd2));
    push("rl_both_wait",  20, pk(2'd1, 0, 1, 0, 2'd0, 2'd2));
    push("rl_both_run",   29, pk(2'd3, 0, 0, 1, 2'd0, 2'd2));
    last = sb[$].at;
    for (int c = 1; c <= last; c++) begin
      @(negedge refclk);
      while (sb.size() > 0 && sb[0].at == c) begin
        e = sb.pop_front();
        checks++;
        if (obs !== e.v) begin
          errors++;
          $display("FAIL %s cycle %0d got %b expected %b", e.nm, c, obs, e.v);
        end
      end
      if (c == 1)  relock_req = 1'b0;
      if (c == 7)  relock_req = 1'b1;
      if (c == 8)  relock_req = 1'b0;
      if (c == 14) locked_in  = 1'b0;
      if (c == 15) relock_req = 1'b1;
      if (c == 16) begin
        relock_req = 1'b0;
        locked_in  = 1'b1;
      end
    end
  endtask

  task automatic test_stable_glitch();
    exp_t e;
    int last;
    relock_req = 1'b1;
    push("sg_reset",      1,  pk(2'd0, 1, 1, 0, 2'd0, 2'd2));
    push("sg_stable",     6,  pk(2'd2, 0, 1, 0, 2'd0, 2'd2));
    push("sg_stable5",    11, pk(2'd2, 0, 1, 0, 2'd0, 2'd2));
    push("sg_back_wait",  12, pk(2'd1, 0, 1, 0, 2'd0, 2'd2));
    push("sg_restable",   13, pk(2'd2, 0, 1, 0, 2'd0, 2'd2));
    push("sg_no_early",   14, pk(2'd2, 0, 1, 0, 2'd0, 2'd2));
    push("sg_fresh7",     20, pk(2'd2, 0, 1, 0, 2'd0, 2'd2));
    push("sg_run",        21, pk(2'd3, 0, 0, 1, 2'd0, 2'd2));
    last = sb[$].at;
    for (int c = 1; c <= last; c++) begin
      @(negedge refclk);
      while (sb.size() > 0 && sb[0].at == c) begin
        e = sb.pop_front();
        checks++;
        if (obs !== e.v) begin
          errors++;
          $display("FAIL %s cycle %0d got %b expected %b", e.nm, c, obs, e.v);
        end
      end
      if (c == 1)  relock_req = 1'b0;
      if (c == 10) locked_in  = 1'b0;
      if (c == 11) locked_in  = 1'b1;
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    int last;
    int rc;
    int rcp;
    rst       = 1'b1;
    locked_in = 1'b0;
    @(negedge refclk);
    @(negedge refclk);
    rst = 1'b0;
    push("to_first_wait", 4, pk(2'd1, 0, 1, 0, 2'd0, 2'd0));
    for (int k = 1; k <= 5; k++) begin
      rc  = (k > 3) ? 3 : k;
      rcp = (k - 1 > 3) ? 3 : k - 1;
      push($sformatf("to_wait_end%0d", k), 24 * k - 1, pk(2'd1, 0, 1, 0, 2'(rcp), 2'd0));
      push($sformatf("to_retry%0d", k),    24 * k,     pk(2'd0, 1, 1, 0, 2'(rc), 2'd0));
      push($sformatf("to_pulse_end%0d", k),24 * k + 3, pk(2'd0, 1, 1, 0, 2'(rc), 2'd0));
      push($sformatf("to_rewait%0d", k),   24 * k + 4, pk(2'd1, 0, 1, 0, 2'(rc), 2'd0));
    end
    push("to_mid_wait", 130, pk(2'd1, 0, 1, 0, 2'd3, 2'd0));
    last = sb[$].at;
    for (int c = 1; c <= last; c++) begin
      @(negedge refclk);
      while (sb.size() > 0 && sb[0].at == c) begin
        e = sb.pop_front();
        checks++;
        if (obs !== e.v) begin
          errors++;
          $display("FAIL %s cycle %0d got %b expected %b", e.nm, c, obs, e.v);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    @(posedge refclk);
    #4;
    checks++;
    if (obs !== pk(2'd1, 0, 1, 0, 2'd3, 2'd0)) begin
      errors++;
      $display("FAIL async_pre got %b expected %b", obs, pk(2'd1, 0, 1, 0, 2'd3, 2'd0));
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== pk(2'd0, 1, 1, 0, 2'd0, 2'd0)) begin
      errors++;
      $display("FAIL async_reset got %b expected %b", obs, pk(2'd0, 1, 1, 0, 2'd0, 2'd0));
    end
    @(negedge refclk);
    rst = 1'b0;
    @(negedge refclk);
    checks++;
    if (obs !== pk(2'd0, 1, 1, 0, 2'd0, 2'd0)) begin
      errors++;
      $display("FAIL async_restart got %b expected %b", obs, pk(2'd0, 1, 1, 0, 2'd0, 2'd0));
    end
  endtask

  initial begin
    rst        = 1'b1;
    locked_in  = 1'b0;
    relock_req = 1'b0;
    test_reset();
    test_lock_up();
    test_run_loss();
    test_relock();
    test_stable_glitch();
    test_timeout();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Controls the rst/locked interface of the system SDRAM PLL from the opposite side: it drives the PLL's rst and consumes its locked output. It pulses PLL reset, waits for lock with a timeout and retry, qualifies lock stability, then releases a system reset for the downstream SDRAM/system logic. It sits in the always-on 50 MHz reference clock domain, ahead of the PLL instance.

Parameters:
RST_CYCLES, 16, cycles pll_rst is held high per reset pulse (min 1)
LOCK_TIMEOUT, 50000, cycles allowed in WAIT_LOCK before retry (1 ms at 50 MHz)
STABLE_CYCLES, 1024, consecutive synchronized-locked cycles required before releasing sys_rst
CNT_W, 8, width of the saturating retry and loss counters

Ports:
refclk  input  1  free-running 50 MHz reference clock; the only clock
rst  input  1  asynchronous, active-high reset
locked_in  input  1  PLL locked; asynchronous to refclk
relock_req  input  1  single-cycle request to force a PLL re-lock
pll_rst  output  1  active-high reset to the PLL
sys_rst  output  1  active-high system reset; high until lock is qualified
ready  output  1  high only in RUN
retry_cnt  output  CNT_W  saturating count of lock timeouts
loss_cnt  output  CNT_W  saturating count of lock losses in RUN
state_o  output  2  current state encoding, for debug

Behaviour:
- Single clock domain: refclk. Reset is asynchronous and active-high on port rst. All outputs are registered.
- locked_in passes through a 2-flop synchronizer to give lock_s. Latency from a locked_in edge to lock_s is 2 refclk edges.
- Reset values: state=RESET_PLL, pll_rst=1, sys_rst=1, ready=0, retry_cnt=0, loss_cnt=0, timer=0, sync flops=0.
- Asserting rst at any time, including mid-sequence, forces reset values immediately without waiting for a clock edge.
- One shared timer, width clog2(max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES))+1. It is cleared on every state entry.
- State encoding: RESET_PLL=0, WAIT_LOCK=1, STABLE_WAIT=2, RUN=3.
- RESET_PLL:
  - pll_rst=1 and sys_rst=1.
  - When timer==RST_CYCLES-1, go to WAIT_LOCK. pll_rst is high for exactly RST_CYCLES cycles.
- WAIT_LOCK:
  - pll_rst=0.
  - If lock_s=1, go to STABLE_WAIT.
  - Else if timer==LOCK_TIMEOUT-1, increment retry_cnt and go to RESET_PLL.
  - If lock and timeout occur in the same cycle, lock wins and there is no retry increment.
- STABLE_WAIT:
  - If lock_s=0, go to WAIT_LOCK. The timer restarts.
  - Else if timer==STABLE_CYCLES-1, go to RUN.
- RUN:
  - sys_rst=0 and ready=1, updated on the same edge that state becomes RUN.
  - If lock_s falls, increment loss_cnt and go to RESET_PLL. sys_rst=1 on that edge.
  - If relock_req=1, go to RESET_PLL with no loss increment.
  - If both occur in the same cycle, go to RESET_PLL and increment loss_cnt.
- relock_req is ignored outside RUN.
- Counters saturate at 2^CNT_W-1 and never wrap. They are cleared only by rst.
- sys_rst is glitch-free: it is a registered output with a single deassertion point (entry to RUN).

Decomposition:
- Shared package pll_seq_pkg:
  - state enum (RESET_PLL, WAIT_LOCK, STABLE_WAIT, RUN) and its 2-bit encoding
  - timer-width function (clog2-based)
- One sub-module: sync_2ff, a reusable 2-flop synchronizer with async active-high reset and reset value 0.
- All FSM, timer and counter logic stays in pll_reset_sequencer.

Test Plan:
Parameters for all scenarios: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, CNT_W=2.
1. Release rst; raise locked_in 3 cycles later and hold it. Required:
   - pll_rst high for exactly 4 cycles, then 0.
   - sys_rst falls exactly 8 cycles after lock_s rises; ready=1 at that point; retry_cnt=0.
2. Hold locked_in=0 forever. Required:
   - Every 4+20 cycles there is a new 4-cycle pll_rst pulse.
   - retry_cnt counts 1, 2, 3, then stays at 3 after the 4th and 5th timeouts (saturation).
   - sys_rst stays 1 throughout.
3. In STABLE_WAIT after 5 stable cycles, drop locked_in for 1 cycle. Required:
   - Return to WAIT_LOCK, then STABLE_WAIT again.
   - sys_rst stays 1 until 8 fresh stable cycles have elapsed.
4. In RUN, drop locked_in. Required:
   - 2 cycles later sys_rst=1, ready=0, loss_cnt=1, state_o=0.
   - 4-cycle pll_rst pulse follows.
   - Restoring locked gives RUN again.
5. In RUN, pulse relock_req, and separately pulse relock_req on the same cycle lock_s falls. Required:
   - First event: RESET_PLL with loss_cnt unchanged.
   - Second event: RESET_PLL with loss_cnt incremented by 1.
6. Assert rst asynchronously mid-WAIT_LOCK, between clock edges. Required:
   - pll_rst=1, sys_rst=1, counters=0, state_o=0 before the next refclk edge.
